gpu_launch_ctrl: RTL and testbench

- Kernel launch controller directly upstream of the GPU core.
- Owns the 128x32 instruction memory and serves the core's combinational fetch port (imem_addr -> imem_data).
- Accepts host program writes, holds the core in reset, releases it on start and supervises execution until the core reports halted, a cycle-limit timeout, or a host abort.
- Reports completion status, cycle count and the final PC.

---
 rtl/gpu_launch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_gpu_launch_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_launch_ctrl.sv
// ============================================================================
// Module   : gpu_launch_ctrl
// Brief    : Kernel launch controller; owns the core's instruction memory,
//            sequences core reset/run and reports completion status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpu_launch_ctrl #(
    parameter int          IMEM_DEPTH = 128,
    parameter int          RST_CYCLES = 2,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_wr_err,
    input  logic        start,
    input  logic        abort,
    input  logic [6:0]  core_imem_addr,
    output logic [31:0] core_imem_data,
    output logic        core_rst_n,
    input  logic        core_halted,
    input  logic [31:0] core_pc,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [31:0] cycle_count,
    output logic [31:0] final_pc
);

    localparam logic [3:0]  c_RST_LOAD   = 4'(RST_CYCLES);
    localparam logic [31:0] c_TIMEOUT_AT = MAX_CYCLES - 32'd1;

    localparam logic [1:0]  c_ST_NONE    = 2'd0;
    localparam logic [1:0]  c_ST_HALTED  = 2'd1;
    localparam logic [1:0]  c_ST_TIMEOUT = 2'd2;
    localparam logic [1:0]  c_ST_ABORTED = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CORE_RST = 2'd1,
        S_RUN      = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_rst_cnt;
    logic [3:0]  w_rst_cnt_nxt;
    logic        r_core_rst_n;
    logic        w_core_rst_n_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_wr_err;
    logic        w_wr_err_nxt;
    logic [1:0]  r_status;
    logic [1:0]  w_status_nxt;
    logic [31:0] r_cycle_count;
    logic [31:0] w_cycle_count_nxt;
    logic [31:0] r_final_pc;
    logic [31:0] w_final_pc_nxt;
    logic        w_mem_we;
    logic        w_timeout;

    // Instruction memory: no reset, contents survive rst_n.
    logic [31:0] r_imem [IMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_imem[host_addr] <= host_wdata;
        end
    end

    assign core_imem_data = r_imem[core_imem_addr];
    assign host_rdata     = r_imem[host_addr];

    assign w_mem_we     = host_we && (r_state == S_IDLE);
    assign w_wr_err_nxt = host_we && (r_state != S_IDLE);
    assign w_timeout    = (r_cycle_count == c_TIMEOUT_AT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= 4'd0;
            r_core_rst_n  <= 1'b0;
            r_done        <= 1'b0;
            r_wr_err      <= 1'b0;
            r_status      <= c_ST_NONE;
            r_cycle_count <= 32'd0;
            r_final_pc    <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_rst_cnt     <= w_rst_cnt_nxt;
            r_core_rst_n  <= w_core_rst_n_nxt;
            r_done        <= w_done_nxt;
            r_wr_err      <= w_wr_err_nxt;
            r_status      <= w_status_nxt;
            r_cycle_count <= w_cycle_count_nxt;
            r_final_pc    <= w_final_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_rst_cnt_nxt     = r_rst_cnt;
        w_core_rst_n_nxt  = 1'b0;
        w_done_nxt        = 1'b0;
        w_status_nxt      = r_status;
        w_cycle_count_nxt = r_cycle_count;
        w_final_pc_nxt    = r_final_pc;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt       = S_CORE_RST;
                    w_rst_cnt_nxt     = c_RST_LOAD;
                    w_cycle_count_nxt = 32'd0;
                end
            end

            S_CORE_RST: begin
                if (abort) begin
                    // Core never left reset, so there is no meaningful PC.
                    w_state_nxt    = S_IDLE;
                    w_done_nxt     = 1'b1;
                    w_status_nxt   = c_ST_ABORTED;
                    w_final_pc_nxt = 32'd0;
                end else begin
                    w_rst_cnt_nxt = r_rst_cnt - 4'd1;
                    if (r_rst_cnt == 4'd1) begin
                        w_state_nxt      = S_RUN;
                        w_core_rst_n_nxt = 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (abort || core_halted || w_timeout) begin
                    w_state_nxt    = S_IDLE;
                    w_done_nxt     = 1'b1;
                    w_final_pc_nxt = core_pc;
                    if (abort) begin
                        w_status_nxt = c_ST_ABORTED;
                    end else if (core_halted) begin
                        w_status_nxt = c_ST_HALTED;
                    end else begin
                        // The timeout cycle is itself a counted RUN cycle.
                        w_status_nxt      = c_ST_TIMEOUT;
                        w_cycle_count_nxt = r_cycle_count + 32'd1;
                    end
                end else begin
                    w_core_rst_n_nxt  = 1'b1;
                    w_cycle_count_nxt = r_cycle_count + 32'd1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign core_rst_n  = r_core_rst_n;
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign host_wr_err = r_wr_err;
    assign status      = r_status;
    assign cycle_count = r_cycle_count;
    assign final_pc    = r_final_pc;

endmodule

`default_nettype wire

// File: tb/tb_gpu_launch_ctrl.sv
// ============================================================================
// Module   : tb_gpu_launch_ctrl
// Brief    : Randomized launch-level bench for gpu_launch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpu_launch_ctrl;

    localparam int c_RSTC = 2;
    localparam int c_MAXC = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        host_we = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [31:0] host_wdata = '0;
    logic [31:0] host_rdata;
    logic        host_wr_err;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  core_imem_addr = '0;
    logic [31:0] core_imem_data;
    logic        core_rst_n;
    logic        core_halted = 1'b0;
    logic [31:0] core_pc = '0;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] final_pc;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] ref_mem [128];

    always #5 clk = ~clk;

    gpu_launch_ctrl #(
        .IMEM_DEPTH (128),
        .RST_CYCLES (c_RSTC),
        .MAX_CYCLES (32'(c_MAXC))
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_rdata     (host_rdata),
        .host_wr_err    (host_wr_err),
        .start          (start),
        .abort          (abort),
        .core_imem_addr (core_imem_addr),
        .core_imem_data (core_imem_data),
        .core_rst_n     (core_rst_n),
        .core_halted    (core_halted),
        .core_pc        (core_pc),
        .busy           (busy),
        .done           (done),
        .status         (status),
        .cycle_count    (cycle_count),
        .final_pc       (final_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_write(input logic [6:0] a, input logic [31:0] d);
        host_we = 1'b1; host_addr = a; host_wdata = d;
        #1 chk("rd_same_cycle_old", host_rdata, ref_mem[a]);
        tick();
        ref_mem[a] = d;
        host_we = 1'b0;
        chk("wr_err_idle", 32'(host_wr_err), 32'd0);
        chk("rd_after_write", host_rdata, d);
    endtask

    // One launch. halt_at/abort_at are RUN-cycle indices (cycle_count value
    // during that cycle); rst_abort_at is the CORE_RST cycle (1..RSTC) to abort in.
    task automatic launch(input int halt_at, input int abort_at, input int rst_abort_at,
                          input int wr_at, input logic [6:0] wr_addr,
                          input bit hold, input bit wr_with_start);
        logic [6:0]  wa;
        logic [31:0] nw;
        logic [1:0]  es;
        logic [31:0] ec, fpc;
        bit exited, ab, hl, we;
        wa = 7'($urandom); nw = $urandom;
        start = 1'b1;
        if (wr_with_start) begin
            host_we = 1'b1; host_addr = wa; host_wdata = nw;
        end
        tick();
        if (wr_with_start) begin
            ref_mem[wa] = nw;
            host_we = 1'b0;
            core_imem_addr = wa;
            #1 chk("fetch_after_wr_start", core_imem_data, nw);
            chk("wr_err_start", 32'(host_wr_err), 32'd0);
        end
        if (!hold) start = 1'b0;
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_core_rst", 32'(core_rst_n), 32'd0);
        chk("launch_cnt_clr", cycle_count, 32'd0);
        chk("launch_done_low", 32'(done), 32'd0);

        for (int k = 2; k <= c_RSTC + 1; k++) begin
            if (k - 1 == rst_abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("rstab_done", 32'(done), 32'd1);
                chk("rstab_status", 32'(status), 32'd3);
                chk("rstab_fpc", final_pc, 32'd0);
                chk("rstab_core_rst", 32'(core_rst_n), 32'd0);
                chk("rstab_busy", 32'(busy), 32'd0);
                if (!hold) begin
                    tick();
                    chk("rstab_done_once", 32'(done), 32'd0);
                end
                return;
            end
            tick();
            chk("core_rst_seq", 32'(core_rst_n), (k == c_RSTC + 1) ? 32'd1 : 32'd0);
        end

        exited = 1'b0;
        for (int n = 0; n <= c_MAXC && !exited; n++) begin
            ab = (n == abort_at);
            hl = (n >= halt_at);
            we = (n == wr_at);
            abort = ab; core_halted = hl; core_pc = $urandom;
            if (we) begin
                host_we = 1'b1; host_addr = wr_addr; host_wdata = ~ref_mem[wr_addr];
            end
            es = 2'd0; ec = 32'(n + 1);
            if (ab) begin exited = 1'b1; es = 2'd3; ec = 32'(n); end
            else if (hl) begin exited = 1'b1; es = 2'd1; ec = 32'(n); end
            else if (n + 1 == c_MAXC) begin exited = 1'b1; es = 2'd2; ec = 32'(c_MAXC); end
            fpc = core_pc;
            tick();
            if (we) begin
                host_we = 1'b0;
                chk("wr_err_busy", 32'(host_wr_err), 32'd1);
                chk("wr_dropped", host_rdata, ref_mem[wr_addr]);
            end
            chk("run_done", 32'(done), exited ? 32'd1 : 32'd0);
            chk("run_cnt", cycle_count, ec);
            chk("run_core_rst", 32'(core_rst_n), exited ? 32'd0 : 32'd1);
            if (exited) begin
                abort = 1'b0; core_halted = 1'b0;
                chk("exit_status", 32'(status), 32'(es));
                chk("exit_fpc", final_pc, fpc);
                chk("exit_busy", 32'(busy), 32'd0);
            end
        end
        if (!exited) chk("run_exit_bound", 32'd0, 32'd1);
        if (!hold) begin
            tick();
            chk("done_once", 32'(done), 32'd0);
            chk("wr_err_clear", 32'(host_wr_err), 32'd0);
        end
    endtask

    initial begin
        logic [1:0] st_keep;
        bit prev_hold;
        int ab_at, rab_at, w_at;
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_core_rst", 32'(core_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_err", 32'(host_wr_err), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_cnt", cycle_count, 32'd0);
        chk("rst_fpc", final_pc, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Fill memory so every word has a known value.
        for (int a = 0; a < 128; a++) begin
            host_we = 1'b1; host_addr = 7'(a); host_wdata = $urandom;
            ref_mem[a] = host_wdata;
            tick();
        end
        host_we = 1'b0;
        idle_write(7'd0, 32'h1000_0000);
        idle_write(7'd1, 32'h2000_0000);
        idle_write(7'd2, 32'hF000_0000);
        for (int a = 0; a < 3; a++) begin
            core_imem_addr = 7'(a);
            #1 chk("fetch_prog", core_imem_data, ref_mem[a]);
        end

        // Directed launches.
        launch(5, -1, 0, -1, 7'd0, 1'b0, 1'b0);
        launch(1000, -1, 0, -1, 7'd0, 1'b0, 1'b0);
        launch(4, 4, 0, -1, 7'd0, 1'b0, 1'b0);
        launch(c_MAXC - 1, -1, 0, -1, 7'd0, 1'b0, 1'b0);
        launch(1000, 6, 0, 3, 7'd5, 1'b0, 1'b0);
        idle_write(7'd5, 32'hCAFE_0005);
        launch(1000, -1, 1, -1, 7'd0, 1'b0, 1'b0);
        launch(1000, -1, c_RSTC, -1, 7'd0, 1'b0, 1'b0);
        launch(3, -1, 0, -1, 7'd0, 1'b0, 1'b1);

        // Abort in IDLE has no effect.
        st_keep = status;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_done", 32'(done), 32'd0);
        chk("idle_abort_status", 32'(status), 32'(st_keep));
        chk("idle_abort_busy", 32'(busy), 32'd0);

        // Back-to-back launches with start held.
        launch(2, -1, 0, -1, 7'd0, 1'b1, 1'b0);
        launch(1000, -1, 0, -1, 7'd0, 1'b1, 1'b0);
        launch(0, -1, 0, -1, 7'd0, 1'b0, 1'b0);

        // Reset mid-RUN.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < c_RSTC + 3; k++) tick();
        chk("pre_rst_run", 32'(core_rst_n), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_core_rst", 32'(core_rst_n), 32'd0);
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            host_addr = 7'(a);
            #1 chk("mem_survives_rst", host_rdata, ref_mem[a]);
        end

        // Randomized launches.
        prev_hold = 1'b0;
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0 && !prev_hold)
                idle_write(7'($urandom), $urandom);
            ab_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            rab_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, c_RSTC)) : 0;
            w_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            begin
                bit h;
                bit ws;
                h  = ($urandom_range(0, 3) == 0) && (it != 29);
                ws = !prev_hold && ($urandom_range(0, 3) == 0);
                launch(int'($urandom_range(0, 14)), ab_at, rab_at, w_at,
                       7'($urandom), h, ws);
                prev_hold = h;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
